// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-path sequencing controller for the vending machine.
// Accumulates coin credit toward PRICE, requests a vend, and pays remaining
// credit back as a greedy stream of quarter/dime/nickel hopper pulses.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   nickel/dime/quarter  one-cycle coin-inserted pulses (5/10/25 cents)
//   cancel       customer cancel request
//   vend_ack     dispenser took the product (one-cycle pulse)
//   credit       registered credit in cents
//   coin_en      coin acceptor may take coins (IDLE/COLLECT)
//   vend_req     dispense request, held until vend_ack
//   reject       registered one-cycle pulse: last sampled coin refused
//   ret_quarter/ret_dime/ret_nickel  change-hopper eject pulses
module vend_sequencer #(
  parameter int unsigned PRICE = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic [7:0] credit,
  output logic       coin_en,
  output logic       vend_req,
  output logic       reject,
  output logic       ret_quarter,
  output logic       ret_dime,
  output logic       ret_nickel
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [8:0] PRICE9 = 9'(PRICE);
  localparam logic [7:0] PRICE8 = 8'(PRICE);

  state_t     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       reject_q, reject_d;

  logic       coin_any;
  logic       coin_one;
  logic [8:0] coin_val;
  logic [8:0] sum;
  logic [7:0] after_vend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;

    coin_any = nickel | dime | quarter;
    // Odd parity is one or three coins; excluding all-three leaves exactly one.
    coin_one = (nickel ^ dime ^ quarter) & ~(nickel & dime & quarter);
    if (quarter)      coin_val = 9'd25;
    else if (dime)    coin_val = 9'd10;
    else if (nickel)  coin_val = 9'd5;
    else              coin_val = '0;
    sum        = {1'b0, credit_q} + coin_val;
    after_vend = credit_q - PRICE8;

    unique case (state_q)
      IDLE, COLLECT: begin
        // Cancel beats a simultaneous coin, even one that would reach PRICE.
        if (cancel && state_q == COLLECT) begin
          state_d  = CHANGE;
          reject_d = coin_any;
        end else if (coin_one) begin
          credit_d = sum[7:0];
          state_d  = (sum >= PRICE9) ? VEND : COLLECT;
        end else if (coin_any) begin
          reject_d = 1'b1;
        end
      end
      VEND: begin
        reject_d = coin_any;
        if (vend_ack) begin
          credit_d = after_vend;
          state_d  = (after_vend == '0) ? IDLE : CHANGE;
        end
      end
      CHANGE: begin
        reject_d = coin_any;
        if (credit_q >= 8'd25)      credit_d = credit_q - 8'd25;
        else if (credit_q >= 8'd10) credit_d = credit_q - 8'd10;
        else if (credit_q >= 8'd5)  credit_d = credit_q - 8'd5;
        else                        credit_d = '0;
        if (credit_d == '0) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_comb begin
    credit      = credit_q;
    reject      = reject_q;
    coin_en     = (state_q == IDLE) || (state_q == COLLECT);
    vend_req    = (state_q == VEND);
    ret_quarter = (state_q == CHANGE) && (credit_q >= 8'd25);
    ret_dime    = (state_q == CHANGE) && (credit_q < 8'd25) && (credit_q >= 8'd10);
    ret_nickel  = (state_q == CHANGE) && (credit_q < 8'd10) && (credit_q >= 8'd5);
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer (PRICE=100). Stimulus pushes expected
// output events (kind, edge number, credit); a negedge monitor pops and
// compares whenever reject, a ret_* pulse or a vend_req rise appears.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       nickel, dime, quarter, cancel, vend_ack;
  logic [7:0] credit;
  logic       coin_en, vend_req, reject, ret_quarter, ret_dime, ret_nickel;

  vend_sequencer #(.PRICE(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .nickel(nickel), .dime(dime), .quarter(quarter),
    .cancel(cancel), .vend_ack(vend_ack),
    .credit(credit), .coin_en(coin_en), .vend_req(vend_req), .reject(reject),
    .ret_quarter(ret_quarter), .ret_dime(ret_dime), .ret_nickel(ret_nickel)
  );

  always #5 clk = ~clk;

  // event kinds: 0 reject, 1 vend_req rise, 2 ret_quarter, 3 ret_dime, 4 ret_nickel
  typedef struct {
    int kind;
    int cyc;
    int cred;
  } ev_t;

  ev_t evq[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  logic prev_vr = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int cred);
    ev_t e;
    e.kind = kind; e.cyc = c; e.cred = cred;
    evq.push_back(e);
  endtask

  task automatic got(input int kind);
    ev_t e;
    total = total + 1;
    if (evq.size() == 0) begin
      bad = bad + 1;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d credit %0d, expected none",
               kind, cyc, credit);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.cred != int'(credit)) begin
        bad = bad + 1;
        $display("FAIL event: got kind %0d cycle %0d credit %0d, expected kind %0d cycle %0d credit %0d",
                 kind, cyc, credit, e.kind, e.cyc, e.cred);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reject)                got(0);
    if (vend_req && !prev_vr)  got(1);
    if (ret_quarter)           got(2);
    if (ret_dime)              got(3);
    if (ret_nickel)            got(4);
    prev_vr = vend_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic n, input logic d, input logic q, input logic c);
    nickel = n; dime = d; quarter = q; cancel = c;
    step();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
  endtask

  task automatic ack();
    vend_ack = 1'b1;
    step();
    vend_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_credit"}, credit, 0);
    check({name, "_vend_req"}, vend_req, 0);
    check({name, "_coin_en"}, coin_en, 1);
    check({name, "_rets"}, {ret_quarter, ret_dime, ret_nickel}, 0);
    check({name, "_reject"}, reject, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    int m;
    nickel = 0; dime = 0; quarter = 0; cancel = 0; vend_ack = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // exact pay: 4 quarters
    drive(0, 0, 1, 0); check("exact_c1", credit, 25);
    drive(0, 0, 1, 0); check("exact_c2", credit, 50);
    drive(0, 0, 1, 0); check("exact_c3", credit, 75);
    push(1, cyc + 1, 100);
    drive(0, 0, 1, 0); check("exact_c4", credit, 100);
    check("exact_vend_req", vend_req, 1);
    check("exact_coin_en", coin_en, 0);
    step();
    ack();
    check("exact_ack_credit", credit, 0);
    check("exact_ack_vend_req", vend_req, 0);
    check("exact_ack_coin_en", coin_en, 1);
    step();

    // overpay: Q Q Q D Q -> 110, refund one dime
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0); check("over_c3", credit, 75);
    drive(0, 1, 0, 0); check("over_c4", credit, 85);
    push(1, cyc + 1, 110);
    drive(0, 0, 1, 0); check("over_c5", credit, 110);
    push(3, cyc + 1, 10);
    ack();
    check("over_ack_credit", credit, 10);
    check("over_ack_vend_req", vend_req, 0);
    step();
    check("over_idle_credit", credit, 0);
    check("over_idle_coin_en", coin_en, 1);

    // cancel at 85: Q Q Q then D, refund
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 0, 0); check("cancel_c", credit, 85);
    m = cyc + 1;
    push(2, m, 85); push(2, m + 1, 60); push(2, m + 2, 35); push(3, m + 3, 10);
    drive(0, 0, 0, 1);
    check("cancel_coin_en", coin_en, 0);
    repeat (4) step();
    check("cancel_end_credit", credit, 0);
    check("cancel_end_coin_en", coin_en, 1);

    // invalid coin pair at 50, coin during VEND
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    push(0, cyc + 1, 50);
    drive(1, 1, 0, 0); check("pair_credit", credit, 50);
    drive(0, 0, 1, 0);
    push(1, cyc + 1, 100);
    drive(0, 0, 1, 0); check("inv_c100", credit, 100);
    push(0, cyc + 1, 100);
    drive(0, 0, 1, 0);
    check("vendcoin_credit", credit, 100);
    check("vendcoin_vend_req", vend_req, 1);
    ack();
    check("inv_ack_credit", credit, 0);
    step();

    // cancel + quarter at 75: reject, refund 3 quarters
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    m = cyc + 1;
    push(0, m, 75); push(2, m, 75); push(2, m + 1, 50); push(2, m + 2, 25);
    drive(0, 0, 1, 1);
    check("cq_credit", credit, 75);
    repeat (3) step();
    check("cq_end_credit", credit, 0);
    check("cq_end_coin_en", coin_en, 1);

    // reset during CHANGE after the first quarter
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    push(2, cyc + 1, 75);
    drive(0, 0, 0, 1);
    #6 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    check("midreset_rel_credit", credit, 0);
    check("midreset_rel_coin_en", coin_en, 1);

    repeat (3) step();
    check("queue_empty", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Sequencing controller for the vending machine coin path. It accumulates coin credit toward a fixed product price and hands a vend request to the dispenser. On vend acknowledge or on customer cancel, it pays back any remaining credit as a greedy stream of quarter/dime/nickel return pulses. It sits between the coin acceptor, the product dispenser and the change hopper, and owns all credit state.

## Interface
- PRICE, default 100: product price in cents. Must be a multiple of 5 with 5 ≤ PRICE ≤ 235.
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- nickel  input  1  coin-inserted pulse, 5 cents; one cycle per coin.
- dime  input  1  coin-inserted pulse, 10 cents.
- quarter  input  1  coin-inserted pulse, 25 cents.
- cancel  input  1  customer cancel request, sampled each cycle.
- vend_ack  input  1  dispenser has taken the product; one-cycle pulse.
- credit  output  8  current credit in cents (registered).
- coin_en  output  1  coin acceptor may take coins.
- vend_req  output  1  dispense request; level, held until vend_ack.
- reject  output  1  one-cycle pulse: the last sampled coin was refused and is returned mechanically.
- ret_quarter, ret_dime, ret_nickel  output  1 each  change-hopper eject pulses; at most one high per cycle.

## Operation
- States: IDLE, COLLECT, VEND, CHANGE. Reset state is IDLE.
- Reset values: credit 0, vend_req 0, reject 0, all ret_* 0, coin_en 1.
- A valid coin is exactly one of nickel/dime/quarter high in a cycle. Two or more high at once is invalid: reject the coin, leave credit unchanged.
- IDLE/COLLECT, valid coin, no cancel:
  - sum = credit + value (9-bit arithmetic).
  - credit ← sum.
  - If sum ≥ PRICE, go to VEND; else go to COLLECT.
- Credit never exceeds PRICE+20, which fits in 8 bits.
- COLLECT with cancel: go to CHANGE and keep credit.
  - A coin in the same cycle is rejected; cancel wins, even when that coin would have reached PRICE.
- IDLE with cancel: ignored (credit is 0).
- VEND:
  - vend_req = 1.
  - Coins are rejected and cancel is ignored.
  - On vend_ack, credit ← credit − PRICE. Go to IDLE if the result is 0, otherwise go to CHANGE.
- CHANGE: one pulse per cycle, chosen greedily from the current credit:
  - credit ≥ 25: ret_quarter, credit −25.
  - else credit ≥ 10: ret_dime, credit −10.
  - else credit ≥ 5: ret_nickel, credit −5.
  - When credit reaches 0, go to IDLE.
  - Coins are rejected and cancel is ignored.
- coin_en = 1 only in IDLE and COLLECT.
- vend_req, coin_en and ret_* decode from the registered state and credit only, with no combinational input paths. reject is a registered pulse.
- Reset mid-operation (any state) forces the reset values immediately. Pending change is discarded and any partial vend is abandoned.

## Timing
- A coin sampled at edge n appears in credit after edge n.
- If that coin reaches PRICE, vend_req is high in the cycle following edge n.
- reject is high for exactly the one cycle following the edge that sampled the refused coin.
- vend_ack sampled at edge m:
  - vend_req is low after edge m.
  - The first ret_* pulse occurs in the cycle following edge m.
- Change pulses are on consecutive cycles with no gaps. Each pulse lasts one cycle.
- Change for credit c takes (c/25 + (c mod 25)/10 + ((c mod 25) mod 10)/5) cycles, then one more edge to reach IDLE with coin_en = 1.
- vend_ack outside VEND is ignored.

## Test plan
- Reset: assert reset_n=0 mid-cycle → credit=0, vend_req=0, coin_en=1, all ret_*=0 immediately, without waiting for a clock edge.
- Exact pay, PRICE=100, four quarters → credit 25, 50, 75, 100. vend_req goes high one cycle after the 4th quarter. vend_ack → credit 0, IDLE, no ret_* pulses.
- Overpay, quarters ×3 then dime then quarter → credit 75, 85, 110, then vend_req. vend_ack → credit 10, a single ret_dime pulse, then IDLE with coin_en=1.
- Cancel at credit 85 (3Q + D), then cancel → ret_quarter on 3 consecutive cycles, then ret_dime once, credit 0, IDLE.
- Invalid and blocked coins:
  - nickel+dime in the same cycle at credit 50 → reject pulse, credit stays 50.
  - quarter during VEND → reject, credit unchanged, vend_req stays 1.
  - cancel+quarter together at credit 75 → reject, then CHANGE paying 3 quarters.
- Reset in CHANGE: assert reset_n=0 after the first ret_quarter of a 3-quarter refund → no further ret_* pulses, credit=0, IDLE after release.
